particle_render: RTL and testbench

PARTICLE_RENDER -- requirements
Module: particle_render

---
 rtl/particle_render.sv | 145 ++++++++++++++
 tb/tb_particle_render.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/particle_render.sv
// Scanned 16x16 LED matrix renderer for three particles: snapshots their positions once per
// frame, then drives one row at a time with latch/blank handshakes and a per-row dwell.

module particle_cell (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [3:0]  col,
    output logic [3:0]  row
);
    logic signed [15:0] xv, yv;
    logic [3:0] yc;

    assign xv = $signed(x) >>> 4;
    assign yv = $signed(y) >>> 4;

    // Clamp the integer cell to 0..15; the screen's row 0 is the top, so y is inverted.
    always_comb begin
        if (xv[15])          col = 4'd0;
        else if (|xv[14:4])  col = 4'd15;
        else                 col = xv[3:0];
        if (yv[15])          yc = 4'd0;
        else if (|yv[14:4])  yc = 4'd15;
        else                 yc = yv[3:0];
        row = 4'd15 - yc;
    end
endmodule

module particle_render #(
    parameter int DWELL = 64,
    parameter int GRID  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [15:0]             x0,
    input  logic [15:0]             y0,
    input  logic [15:0]             x1,
    input  logic [15:0]             y1,
    input  logic [15:0]             x2,
    input  logic [15:0]             y2,
    output logic [$clog2(GRID)-1:0] row_sel,
    output logic [GRID-1:0]         col_data,
    output logic                    latch,
    output logic                    blank,
    output logic                    frame_done,
    output logic                    busy
);
    localparam int NUM_P = 3;
    localparam int RW    = $clog2(GRID);
    localparam int DW    = 10;

    typedef enum logic [2:0] {IDLE, SNAP, BUILD, SHOW, BLANK} state_t;

    state_t                       state;
    logic [NUM_P-1:0][15:0]       pos_x, pos_y;
    logic [NUM_P-1:0][3:0]        cell_col, cell_row;
    logic [NUM_P-1:0][3:0]        snap_col, snap_row;
    logic [RW-1:0]                row_cnt;
    logic [DW-1:0]                dwell_cnt;
    logic [GRID-1:0]              col_data_next;

    assign pos_x = {x2, x1, x0};
    assign pos_y = {y2, y1, y0};

    for (genvar g = 0; g < NUM_P; g++) begin : g_cell
        particle_cell u_cell (
            .x   (pos_x[g]),
            .y   (pos_y[g]),
            .col (cell_col[g]),
            .row (cell_row[g])
        );
    end

    // Coincident particles simply OR into the same bit.
    always_comb begin
        col_data_next = '0;
        for (int i = 0; i < NUM_P; i++)
            if (snap_row[i] == row_cnt) col_data_next[snap_col[i]] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            row_cnt    <= '0;
            dwell_cnt  <= '0;
            snap_col   <= '0;
            snap_row   <= '0;
            row_sel    <= '0;
            col_data   <= '0;
            blank      <= 1'b1;
            latch      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            latch      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    blank <= 1'b1;
                    if (enable) begin
                        state <= SNAP;
                        busy  <= 1'b1;
                    end
                end
                SNAP: begin
                    snap_col <= cell_col;
                    snap_row <= cell_row;
                    row_cnt  <= '0;
                    state    <= BUILD;
                end
                BUILD: begin
                    row_sel   <= row_cnt;
                    col_data  <= col_data_next;
                    latch     <= 1'b1;
                    blank     <= 1'b0;
                    dwell_cnt <= '0;
                    state     <= SHOW;
                end
                SHOW: begin
                    if (dwell_cnt == DW'(DWELL - 1)) begin
                        blank <= 1'b1;
                        state <= BLANK;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (row_cnt != RW'(GRID - 1)) begin
                        row_cnt <= row_cnt + 1'b1;
                        state   <= BUILD;
                    end else begin
                        frame_done <= 1'b1;
                        if (enable) begin
                            state <= SNAP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_particle_render.sv
// Scoreboard bench for particle_render at DWELL=4: expected rows are queued when a frame is
// set up and compared at every latch pulse; frame timing and reset behaviour are checked directly.

module tb_particle_render;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic [3:0]  row_sel;
    logic [15:0] col_data;
    logic        latch, blank, frame_done, busy;

    typedef struct {
        logic [3:0]  row;
        logic [15:0] cols;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  total = 0, bad = 0;
    int  cyc = 0, latch_total = 0, busy_low = 0;
    int  t0, l0, b0;

    particle_render #(.DWELL(4), .GRID(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .latch      (latch),
        .blank      (blank),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (latch) begin
            latch_total++;
            chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("latch_row", 32'(row_sel), 32'(mon_e.row));
                chk("latch_cols", 32'(col_data), 32'(mon_e.cols));
                chk("latch_blank", 32'(blank), 0);
            end
        end
        if (!busy && !frame_done) busy_low++;
    end

    task automatic push_sparse(input logic [3:0] ra, input logic [15:0] ca,
                               input logic [3:0] rb, input logic [15:0] cb);
        sb_t e;
        for (int r = 0; r < 16; r++) begin
            e.row  = r[3:0];
            e.cols = ((r == int'(ra)) ? ca : 16'h0) | ((r == int'(rb)) ? cb : 16'h0);
            sb_q.push_back(e);
        end
    endtask

    task automatic set_pos(input logic [15:0] ax0, ay0, ax1, ay1, ax2, ay2);
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2;
    endtask

    task automatic wait_fd(input int maxc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < maxc);
        chk("frame_done_wait", 32'(frame_done), 1);
    endtask

    task automatic wait_latch_row(input logic [3:0] r, input int maxc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(latch && row_sel == r) && n < maxc);
        chk("latch_wait", 32'(latch && row_sel == r), 1);
    endtask

    // One frame with enable released right after the start.
    task automatic run_frame();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_fd(200);
    endtask

    initial begin
        #23;
        chk("rst_row_sel", 32'(row_sel), 0);
        chk("rst_col_data", 32'(col_data), 0);
        chk("rst_blank", 32'(blank), 1);
        chk("rst_latch", 32'(latch), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_blank", 32'(blank), 1);

        // Two back-to-back frames; enable dropped mid second frame, which still completes.
        set_pos(16'd128, 16'd128, 16'd0, 16'd0, 16'd0, 16'd0);
        push_sparse(4'd7, 16'h0100, 4'd15, 16'h0001);
        push_sparse(4'd7, 16'h0100, 4'd15, 16'h0001);
        enable = 1'b1;
        wait_fd(200);
        t0 = cyc; l0 = latch_total; b0 = busy_low;
        enable = 1'b0;
        wait_fd(200);
        chk("fd_period", 32'(cyc - t0), 97);
        chk("latch_per_frame", 32'(latch_total - l0), 16);
        chk("busy_gaps", 32'(busy_low - b0), 0);
        @(negedge clk);
        chk("end_busy", 32'(busy), 0);
        chk("end_blank", 32'(blank), 1);

        // Clamping of negative and oversized coordinates.
        set_pos(-16'sd5, 16'd300, 16'd0, 16'd0, 16'd0, 16'd0);
        push_sparse(4'd0, 16'h0001, 4'd15, 16'h0001);
        run_frame();

        // Coincident particles light a single bit.
        set_pos(16'd32, 16'd48, 16'd32, 16'd48, 16'd32, 16'd48);
        push_sparse(4'd12, 16'h0004, 4'd12, 16'h0004);
        run_frame();

        // Two particles share a row, the third clamps to the bottom-right corner.
        set_pos(16'd48, 16'd160, 16'd144, 16'd160, 16'd248, -16'sd100);
        push_sparse(4'd5, 16'h0208, 4'd15, 16'h8000);
        run_frame();

        // Position change mid-frame only takes effect at the next snapshot.
        set_pos(16'd128, 16'd128, 16'd0, 16'd0, 16'd0, 16'd0);
        push_sparse(4'd7, 16'h0100, 4'd15, 16'h0001);
        enable = 1'b1;
        wait_latch_row(4'd3, 100);
        x0 = 16'd0;
        push_sparse(4'd7, 16'h0001, 4'd15, 16'h0001);
        wait_fd(200);
        enable = 1'b0;
        wait_fd(200);

        // Asynchronous reset during row 5 abandons the frame.
        set_pos(16'd128, 16'd128, 16'd0, 16'd0, 16'd0, 16'd0);
        push_sparse(4'd7, 16'h0100, 4'd15, 16'h0001);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_latch_row(4'd5, 100);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_blank", 32'(blank), 1);
        chk("arst_col_data", 32'(col_data), 0);
        chk("arst_row_sel", 32'(row_sel), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_latch", 32'(latch), 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        push_sparse(4'd7, 16'h0100, 4'd15, 16'h0001);
        run_frame();

        chk("sb_drain", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
